poly1305_mac_ctrl: RTL
======================

// Module: poly1305_mac_ctrl
// PURPOSE
//  Poly1305 accumulator/controller acting as initiator for the 130x128 limb multiplier (mult_130x128_limb).
//  Accepts 16-byte message blocks, computes h = ((h + m) * r) mod 2^130-5 by driving the multiplier's
//  start/busy/done handshake, reduces the 258-bit product, and emits tag = (h + s) mod 2^128 on finalize.
//  Sits between the GCM/MAC datapath block feeder and the shared multiplier instance.
// PARAMETERS
//  CLAMP_R      1   1: r &= 0x0ffffffc0ffffffc0ffffffc0fffffff on key_load; 0: r used as given
//  MUL_TIMEOUT  64  max cycles in MWAIT before err is set (0 disables)
// PORTS
//  clk          in   1    clock, all logic on rising edge
//  reset        in   1    asynchronous, active-high reset
//  key_load     in   1    pulse: latch r_in/s_in, clear h
//  r_in         in   128  key part r (little-endian bytes, byte0 = [7:0])
//  s_in         in   128  key part s
//  blk_valid    in   1    message block offered
//  blk_ready    out  1    block accepted when blk_valid & blk_ready
//  blk_data     in   128  block bytes, byte0 = [7:0]
//  blk_len      in   5    bytes in block, 1..16 (0 or >16 treated as 16)
//  finalize     in   1    pulse: produce tag from current h
//  tag_out      out  128  tag, held until next tag_valid
//  tag_valid    out  1    one-cycle pulse, tag_out valid
//  busy         out  1    high in every state except IDLE
//  err          out  1    sticky: multiplier timeout; cleared by reset or key_load
//  mul_start    out  1    one-cycle start pulse to multiplier
//  mul_a        out  130  h + m (fully reduced, < p)
//  mul_b        out  128  r
//  mul_busy     in   1    multiplier busy
//  mul_done     in   1    multiplier done pulse; mul_product valid same cycle
//  mul_product  in   258  a*b
// BEHAVIOUR
//  Reset: all outputs 0, h=0, r=s=0, key_ok=0, state IDLE. Reset mid-block aborts; stale mul_done ignored.
//  States: IDLE -> ADD -> MREQ -> MWAIT -> RED -> IDLE; IDLE -> FIN -> IDLE.
//  IDLE: blk_ready = key_ok & ~key_load. Priority: key_load > block accept > finalize.
//   key_load: r <= clamp(r_in), s <= s_in, h <= 0, key_ok <= 1, err <= 0; stay IDLE. Ignored outside IDLE.
//   block accept: m = blk_data[8n-1:0] + 2^(8n), n = blk_len; latch m; -> ADD.
//   finalize with ~blk_valid & key_ok: -> FIN. Finalize alongside blk_valid, or outside IDLE, is dropped.
//  ADD: u = h + m (131 b); u = u[129:0] + 5*u[130]; if u >= p: u -= p. mul_a <= u, mul_b <= r; -> MREQ.
//  MREQ: hold while mul_busy. Otherwise mul_start = 1 for exactly one cycle; -> MWAIT.
//  MWAIT: wait for mul_done; product not sampled on any other cycle.
//   On mul_done: t = P[129:0] + 5*P[257:130] (133 b) registered; -> RED.
//   Timeout: MUL_TIMEOUT cycles without done -> err <= 1, h unchanged, -> IDLE.
//  RED: h = t[129:0] + 5*t[132:130]; if h >= p: h -= p (one subtract suffices, h < 2p); -> IDLE.
//   Invariant: h < p = 2^130-5 in IDLE.
//  FIN: tag_out <= (h + {2'b0,s})[127:0]; tag_valid = 1 this cycle; h <= 0 (key kept); -> IDLE.
//  Timing: mul_start 2 cycles after accept edge (if ~mul_busy). blk_ready high 2 cycles after mul_done.
//   tag_valid 1 cycle after finalize accept.
//  mul_done while not in MWAIT: ignored. mul_start never asserted while mul_busy.
// TESTING
//  RFC 8439 2.5.2 vector: r=85d6be7857556d337f4452fe42d506a8, s=01038 08afb0db2fd4abff6af4149f51b
//   (byte order as listed), msg "Cryptographic Forum Research Group" (2x16 + 2 bytes)
//   -> tag a8061dc1305136c6c22b8baf0c0127a9.
//  key_load, finalize with no blocks -> tag_out == s, tag_valid one cycle, busy high 1 cycle.
//  CLAMP_R=0, r=1, s=0, two 16-byte blocks of all 0xFF -> h=2^130-2 reduced -> tag_out == 3 (cond-sub path).
//  blk_valid & finalize same cycle in IDLE -> block accepted, no tag_valid. mul_busy held 5 cycles in MREQ
//   -> mul_start delayed, single pulse.
//  reset asserted in MWAIT, then late mul_done -> state IDLE, h=0, blk_ready=0 until key_load.
//  mul_done withheld MUL_TIMEOUT cycles -> err=1, back to IDLE. key_load -> err=0.

Source files
------------

// File: rtl/poly1305_mac_ctrl.sv
// -----------------------------------------------------------------------------
// poly1305_mac_ctrl
//   Poly1305 accumulator and controller. It acts as the initiator for a shared
//   130x128 limb multiplier. Each accepted 16-byte message block updates
//   h = ((h + m) * r) mod (2^130 - 5). The multiplier is driven through a
//   start/busy/done handshake, and its 258-bit product is folded back below p.
//   On finalize the block emits tag = (h + s) mod 2^128.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   key_load, r_in,   load key (r optionally clamped), clear h and err
//   s_in
//   blk_valid/ready,  message block handshake; blk_len 1..16 (0 or >16 -> 16)
//   blk_data, blk_len
//   finalize          request tag from current h
//   tag_out/tag_valid tag result (held) and one-cycle valid pulse
//   busy, err         not-idle flag; sticky multiplier-timeout flag
//   mul_*             multiplier initiator interface
// -----------------------------------------------------------------------------
module poly1305_mac_ctrl #(
   parameter bit CLAMP_R     = 1'b1,
   parameter int MUL_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_load,
   input  logic [127:0] r_in,
   input  logic [127:0] s_in,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [127:0] blk_data,
   input  logic [4:0]   blk_len,
   input  logic         finalize,
   output logic [127:0] tag_out,
   output logic         tag_valid,
   output logic         busy,
   output logic         err,
   output logic         mul_start,
   output logic [129:0] mul_a,
   output logic [127:0] mul_b,
   input  logic         mul_busy,
   input  logic         mul_done,
   input  logic [257:0] mul_product
);

   localparam logic [129:0] P          = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
   localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
   localparam int           TW         = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(MUL_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_ADD, S_MREQ, S_MWAIT, S_RED, S_FIN} state_t;

   state_t          state_reg;
   logic [129:0]    h_reg;
   logic [127:0]    r_reg;
   logic [127:0]    s_reg;
   logic [128:0]    m_reg;
   logic [132:0]    t_reg;
   logic            key_ok_reg;
   logic [TW-1:0]   tmo_cnt_reg;

   // Block padding: keep bytes below blk_len, put the 0x01 pad byte at position
   // blk_len, zero everything above. Bit 128 is the pad for a full block.
   logic [4:0]      blen_eff;
   logic [128:0]    m_in;

   assign blen_eff = (blk_len == 5'd0 || blk_len > 5'd16) ? 5'd16 : blk_len;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi = gi + 1) begin : g_pad
         assign m_in[8*gi +: 8] = (5'(gi) < blen_eff)  ? blk_data[8*gi +: 8] :
                                  (5'(gi) == blen_eff) ? 8'h01 : 8'h00;
      end
   endgenerate
   assign m_in[128] = (blen_eff == 5'd16);

   // Arithmetic datapath
   logic [130:0] add_u, add_f, add_sub;
   logic [129:0] add_res;
   logic [132:0] t_next;
   logic [5:0]   t_hi5;
   logic [130:0] red_f, red_sub;
   logic [129:0] red_res;
   logic [127:0] tag_sum;

   always_comb begin
      // h < p and m < 2^129, so one fold of bit 130 plus one conditional
      // subtract leaves the sum fully reduced.
      add_u   = {1'b0, h_reg} + {2'b0, m_reg};
      add_f   = {1'b0, add_u[129:0]} + (add_u[130] ? 131'd5 : 131'd0);
      add_sub = add_f - {1'b0, P};
      add_res = (add_f >= {1'b0, P}) ? add_sub[129:0] : add_f[129:0];

      // 2^130 == 5 (mod p): fold the high part of the product as 4*x + x.
      t_next  = {3'b0, mul_product[129:0]}
              + {3'b0, mul_product[257:130], 2'b0}
              + {5'b0, mul_product[257:130]};

      t_hi5   = {1'b0, t_reg[132:130], 2'b0} + {3'b0, t_reg[132:130]};
      red_f   = {1'b0, t_reg[129:0]} + {125'b0, t_hi5};
      red_sub = red_f - {1'b0, P};
      red_res = (red_f >= {1'b0, P}) ? red_sub[129:0] : red_f[129:0];

      tag_sum = h_reg[127:0] + s_reg;
   end

   assign busy      = (state_reg != S_IDLE);
   assign blk_ready = (state_reg == S_IDLE) & key_ok_reg & ~key_load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         h_reg       <= '0;
         r_reg       <= '0;
         s_reg       <= '0;
         m_reg       <= '0;
         t_reg       <= '0;
         key_ok_reg  <= 1'b0;
         tmo_cnt_reg <= '0;
         tag_out     <= '0;
         tag_valid   <= 1'b0;
         err         <= 1'b0;
         mul_start   <= 1'b0;
         mul_a       <= '0;
         mul_b       <= '0;
      end else begin
         tag_valid <= 1'b0;
         mul_start <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (key_load) begin
                  r_reg      <= CLAMP_R ? (r_in & CLAMP_MASK) : r_in;
                  s_reg      <= s_in;
                  h_reg      <= '0;
                  key_ok_reg <= 1'b1;
                  err        <= 1'b0;
               end else if (blk_valid && key_ok_reg) begin
                  m_reg     <= m_in;
                  state_reg <= S_ADD;
               end else if (finalize && !blk_valid && key_ok_reg) begin
                  tag_out   <= tag_sum;
                  tag_valid <= 1'b1;
                  state_reg <= S_FIN;
               end
            end
            S_ADD: begin
               mul_a     <= add_res;
               mul_b     <= r_reg;
               state_reg <= S_MREQ;
            end
            S_MREQ: begin
               if (!mul_busy) begin
                  mul_start   <= 1'b1;
                  tmo_cnt_reg <= '0;
                  state_reg   <= S_MWAIT;
               end
            end
            S_MWAIT: begin
               if (mul_done) begin
                  t_reg     <= t_next;
                  state_reg <= S_RED;
               end else if (MUL_TIMEOUT != 0 && tmo_cnt_reg == TMO_LAST) begin
                  // Abandon the block; h keeps its pre-block value.
                  err       <= 1'b1;
                  state_reg <= S_IDLE;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end
            S_RED: begin
               h_reg     <= red_res;
               state_reg <= S_IDLE;
            end
            S_FIN: begin
               h_reg     <= '0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule
